// File: rtl/uart_frame_rx.sv
// Frame parser between a FWFT UART receive FIFO and a valid/ready byte stream.
// Frame: SOF, LEN, LEN payload bytes, CHK (mod-2^DBIT sum of LEN and payload).
module uart_frame_rx #(
  parameter int              DBIT    = 8,
  parameter int              MAX_LEN = 16,
  parameter logic [DBIT-1:0] SOF     = 8'hA5,
  parameter int              TIMEOUT = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] rx_data,
  input  logic            rx_empty,
  output logic            rd_uart,
  output logic [DBIT-1:0] m_data,
  output logic            m_valid,
  output logic            m_last,
  input  logic            m_ready,
  output logic            frame_ok,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic [2:0]      dbg_state
);

  // Handshake: a payload byte transfers on a rising edge where m_valid and
  // m_ready are both 1; while m_valid=1 and m_ready=0, m_data/m_last hold.

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_EMIT    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DBIT-1:0] sum_q, sum_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            wr_en;
  logic            pop;
  logic            at_last;
  logic [DBIT-1:0] buf_q [MAX_LEN];

  assign pop     = ~rx_empty && (state_q != S_EMIT);
  assign at_last = (idx_q == len_q - IW'(1));

  assign rd_uart   = pop && !reset;
  assign m_valid   = (state_q == S_EMIT);
  assign m_data    = m_valid ? buf_q[idx_q[AW-1:0]] : '0;
  assign m_last    = m_valid && at_last;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Payload storage is plain memory; frames are only read after a full rewrite.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[idx_q[AW-1:0]] <= rx_data;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    tmo_d   = tmo_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    wr_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (pop && rx_data == SOF) state_d = S_LEN;
      end

      S_LEN, S_PAYLOAD, S_CHK: begin
        if (pop) begin
          tmo_d = '0;
          if (state_q == S_LEN) begin
            if (rx_data == '0 || rx_data > DBIT'(MAX_LEN)) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = 2'd1;
            end else begin
              len_d   = IW'(rx_data);
              sum_d   = rx_data;
              idx_d   = '0;
              state_d = S_PAYLOAD;
            end
          end else if (state_q == S_PAYLOAD) begin
            wr_en = 1'b1;
            sum_d = sum_q + rx_data;
            if (at_last) begin
              idx_d   = '0;
              state_d = S_CHK;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            idx_d = '0;
            if (rx_data == sum_q) begin
              state_d = S_EMIT;
              ok_d    = 1'b1;
              code_d  = 2'd0;
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = 2'd2;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT-th consecutive empty cycle: abandon the partial frame.
          tmo_d   = '0;
          idx_d   = '0;
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = 2'd3;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_EMIT: begin
        if (m_ready) begin
          if (at_last) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a queue models the FWFT receive FIFO and a
// monitor logs handshakes and status pulses for comparison against tables.
module tb_uart_frame_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rd_uart;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  uart_frame_rx #(
    .DBIT(8), .MAX_LEN(16), .SOF(8'hA5), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic [7:0] fifo[$];
  logic       pop_pending = 1'b0;
  int         cyc = 0;
  int         last_pop_cyc = 0;

  always @(negedge clk) pop_pending = rd_uart;

  always @(posedge clk) begin
    cyc++;
    if (pop_pending && fifo.size() > 0) begin
      void'(fifo.pop_front());
      last_pop_cyc = cyc;
    end
    #1;
    rx_empty = (fifo.size() == 0);
    rx_data  = rx_empty ? 8'h00 : fifo[0];
  end

  // ---------------- monitor ----------------
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  int valid_cyc = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int err_cyc = 0;

  always @(negedge clk) begin
    if (m_valid) valid_cyc++;
    if (m_valid && m_ready) obs_q.push_back({m_last, m_data});
    if (frame_ok) ok_cnt++;
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (frame_ok && frame_err) both_cnt++;
  end

  // ---------------- scoreboard / helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    obs_q.delete();
    exp_q.delete();
    valid_cyc = 0;
    ok_cnt    = 0;
    err_cnt   = 0;
    both_cnt  = 0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    repeat (2) step();
    while (!(fifo.size() == 0 && rx_empty && dbg_state == 3'd0) && n < 150) begin
      step();
      n++;
    end
    check({"drain_", nm}, (n < 150) ? 1 : 0, 1);
    repeat (3) step();
  endtask

  task automatic compare_stream(input string nm);
    int n;
    check({"n_out_", nm}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({"data_", nm}, {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    int           n_in;
    logic [159:0] in_b;
    int           n_out;
    logic [127:0] out_b;
    int           exp_ok;
    int           exp_err;
    logic [1:0]   exp_code;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input int ni, input logic [159:0] ib,
                         input int no, input logic [127:0] ob,
                         input int eo, input int ee, input logic [1:0] ec);
    vec_t v;
    v.name = nm; v.n_in = ni; v.in_b = ib; v.n_out = no; v.out_b = ob;
    v.exp_ok = eo; v.exp_err = ee; v.exp_code = ec;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    clear_logs();
    m_ready = 1'b1;
    for (int i = 0; i < v.n_out; i++)
      exp_q.push_back({(i == v.n_out - 1), v.out_b[8*(v.n_out-1-i) +: 8]});
    for (int i = 0; i < v.n_in; i++)
      fifo.push_back(v.in_b[8*(v.n_in-1-i) +: 8]);
    wait_drain(v.name);
    compare_stream(v.name);
    check({"valid_cyc_", v.name}, valid_cyc, v.n_out);
    check({"ok_", v.name}, ok_cnt, v.exp_ok);
    check({"err_", v.name}, err_cnt, v.exp_err);
    check({"code_", v.name}, {30'd0, err_code}, {30'd0, v.exp_code});
    check({"both_", v.name}, both_cnt, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    add_vec("good3", 6, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69},
            3, {8'h11, 8'h22, 8'h33}, 1, 0, 2'd0);
    add_vec("badchk", 6, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00},
            0, 128'd0, 0, 1, 2'd2);
    add_vec("badlen", 4, {8'hA5, 8'h00, 8'hA5, 8'h11},
            0, 128'd0, 0, 2, 2'd1);
    add_vec("recover1", 4, {8'hA5, 8'h01, 8'h7E, 8'h7F},
            1, {8'h7E}, 1, 0, 2'd0);
    add_vec("garbage", 7, {8'h00, 8'hFF, 8'h42, 8'hA5, 8'h01, 8'h7E, 8'h7F},
            1, {8'h7E}, 1, 0, 2'd0);
    add_vec("sof_in_data", 5, {8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C},
            2, {8'hA5, 8'hA5}, 1, 0, 2'd0);
    add_vec("sum_wrap", 5, {8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00},
            2, {8'hFF, 8'hFF}, 1, 0, 2'd0);
    add_vec("maxlen", 19, {8'hA5, 8'h10,
            8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h88},
            16, {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F}, 1, 0, 2'd0);
    add_vec("len_over", 3, {8'hA5, 8'h11, 8'h00}, 0, 128'd0, 0, 1, 2'd1);

    // Reset state, with a byte waiting so rd_uart must be held low by reset.
    fifo.push_back(8'h42);
    repeat (3) step();
    check("rst_rd_uart", rd_uart, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    reset = 1'b0;
    clear_logs();
    wait_drain("rst_garbage");
    check("rst_garbage_err", err_cnt, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Inter-byte timeout: frame_err 16 cycles after the last pop.
    begin
      int n;
      clear_logs();
      fifo.push_back(8'hA5); fifo.push_back(8'h02); fifo.push_back(8'h10);
      n = 0;
      while (err_cnt == 0 && n < 80) begin
        step();
        n++;
      end
      check("tmo_seen", (n < 80) ? 1 : 0, 1);
      check("tmo_delay", err_cyc - last_pop_cyc, 16);
      repeat (3) step();
      check("tmo_err_cnt", err_cnt, 1);
      check("tmo_code", err_code, 3);
      check("tmo_valid", valid_cyc, 0);
      check("tmo_ok", ok_cnt, 0);
    end

    // Backpressure, then reset in the middle of EMIT.
    begin
      int n;
      clear_logs();
      m_ready = 1'b0;
      fifo.push_back(8'hA5); fifo.push_back(8'h03); fifo.push_back(8'h11);
      fifo.push_back(8'h22); fifo.push_back(8'h33); fifo.push_back(8'h69);
      fifo.push_back(8'h00);
      n = 0;
      while (!m_valid && n < 40) begin
        step();
        n++;
      end
      check("bp_valid_seen", (n < 40) ? 1 : 0, 1);
      for (int i = 0; i < 10; i++) begin
        check("bp_valid", m_valid, 1);
        check("bp_data", m_data, 8'h11);
        check("bp_last", m_last, 0);
        check("bp_rd_uart", rd_uart, 0);
        step();
      end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("bp_adv_data", m_data, 8'h22);
      check("bp_adv_valid", m_valid, 1);
      check("bp_ok", ok_cnt, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", m_valid, 0);
      check("mid_rst_rd_uart", rd_uart, 0);
      step();
      reset = 1'b0;
      m_ready = 1'b1;
      wait_drain("post_rst_drop");
      clear_logs();
      fifo.push_back(8'hA5); fifo.push_back(8'h01);
      fifo.push_back(8'h7E); fifo.push_back(8'h7F);
      exp_q.push_back({1'b1, 8'h7E});
      wait_drain("post_rst");
      compare_stream("post_rst");
      check("post_rst_ok", ok_cnt, 1);
      check("post_rst_err", err_cnt, 0);
      check("post_rst_code", err_code, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
